ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
- Keyboard-side consumer of the PS/2 serial stream generated by the host I/O bridge (its ps2_kbd_clk / ps2_kbd_data outputs).
- Deserialises 11-bit frames and validates them.
- Folds the E0 (extended), F0 (release) and E1 (Pause) prefixes into single key events.
- Queues events in a small FIFO with a valid/ready interface to the core's keyboard matrix logic.

Parameters:
- TIMEOUT, 20000, clk_sys cycles without a falling ps2_clk edge mid-frame before the frame is abandoned.
- FIFO_BITS, 2, log2 of event FIFO depth (depth 4 at default).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  PS/2 clock, asynchronous to clk_sys.
- ps2_data  in  1  PS/2 data, asynchronous to clk_sys.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event.
- ev_data  out  10  head event {ext, release, code[7:0]}.
- ovf  out  1  sticky flag: an event was dropped because the FIFO was full.
- ovf_clr  in  1  clears ovf.
- err_cnt  out  8  saturating count of rejected frames.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: ev_valid=0, ev_data=0, ovf=0, err_cnt=0.
  - State: FIFO empty, receiver in IDLE, prefix flags cleared, synchronisers set to 1.
  - Reset mid-frame discards the partial frame.
- Input sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge is sync_clk previous=1, current=0. Data is sampled on that cycle.
- Receiver FSM:
  - IDLE: on falling edge with data=0 go to DATA with bit_cnt=0. Falling edge with data=1 is ignored.
  - DATA: shift 8 bits LSB first; after the 8th bit go to PARITY.
  - PARITY: latch bit; go to STOP.
  - STOP: on falling edge, frame is valid iff data=1 and the 9 bits (data+parity) have odd parity. Either way return to IDLE.
- Watchdog: counter reset on every falling edge; in any state other than IDLE it reaches TIMEOUT → return to IDLE, err_cnt+1, prefix flags cleared.
- Invalid frame (parity or stop error): byte discarded, err_cnt+1 (saturates at 255), prefix flags cleared.
- Decoder, valid byte b (skip counter checked first):
  - skip_cnt≠0: decrement; when it reaches 0 emit {1,0,0x77}.
  - b=E1: skip_cnt=7, no event.
  - b=E0: ext_f=1, no event.
  - b=F0: rel_f=1, no event.
  - Any other byte: emit {ext_f, rel_f, b}, then clear both flags.
  - E1 sequence: E1 plus 7 bytes yields exactly one Pause event; it is make-only, with no release event.
- Latency: an event from a valid frame is pushed the cycle after the STOP sample. ev_valid is high within 4 clk_sys cycles of the stop-bit falling ps2_clk edge (raw input).
- FIFO:
  - Depth 2^FIFO_BITS; first-word fall-through; ev_data shows the head whenever ev_valid=1.
  - Pop when ev_valid & ev_ready.
  - Push while full with no pop in the same cycle: event dropped, ovf=1.
  - Push and pop in the same cycle while full: both succeed, no drop.
  - Pointers wrap modulo depth; full/empty are distinguished by an extra pointer bit.
- ovf_clr: clears ovf. If a drop occurs in the same cycle, ovf stays 1 (set wins).
- ev_data holds its last value while ev_valid=0; consumers ignore it.

Test Plan:
- Frame 0x1C (odd parity bit 0, stop 1), ev_ready=1 → one event ev_data=0x01C within 4 cycles; err_cnt=0.
- Sequence E0,F0,0x75 → single event ev_data=0x375 (ext=1, rel=1); prefix flags clear afterwards, so a following 0x75 gives 0x075.
- Sequence E1,14,77,E1,F0,14,F0,77 → exactly one event 0x277; no other events.
- Frame 0x1C with wrong parity, then frame 0x1C with stop=0 → no events, err_cnt=2. Abort after 4 data bits and wait TIMEOUT+10 cycles → err_cnt=3; the next good frame 0x29 gives 0x029.
- ev_ready=0, send 5 make codes 0x16,0x1E,0x26,0x25,0x2E → 4 queued, ovf=1. Raise ev_ready → pops 0x016,0x01E,0x026,0x025 in order, then ev_valid=0. Pulse ovf_clr → ovf=0.
- Assert reset_n=0 mid-frame with 2 events queued → ev_valid=0, ovf=0, err_cnt=0 immediately (async). After release, a clean frame 0x5A gives 0x05A.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard stream receiver.
// Deserialises 11-bit PS/2 frames, checks parity and stop bits, and folds the
// E0 (extended), F0 (release) and E1 (Pause) prefixes into single key events.
// Events are queued in a first-word fall-through FIFO with a valid/ready handshake.
//
// State table (receiver FSM)
//   state    | meaning
//   S_IDLE   | waiting for a start bit (falling ps2_clk with data low)
//   S_DATA   | shifting in 8 data bits, LSB first
//   S_PARITY | capturing the odd-parity bit
//   S_STOP   | capturing the stop bit, then validating and decoding the byte
//
// Ports
//   clk_sys   in   system clock
//   reset_n   in   asynchronous active-low reset
//   ps2_clk   in   PS/2 clock (asynchronous)
//   ps2_data  in   PS/2 data (asynchronous)
//   ev_valid  out  FIFO head holds an event
//   ev_ready  in   consumer accepts the head event
//   ev_data   out  head event {ext, release, code[7:0]}
//   ovf       out  sticky: an event was dropped on a full FIFO
//   ovf_clr   in   clears ovf (a same-cycle drop wins)
//   err_cnt   out  saturating count of rejected frames
module ps2_kbd_rx #(
  parameter int TIMEOUT   = 20000,
  parameter int FIFO_BITS = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [9:0] ev_data,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic [7:0] err_cnt
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

  // Input synchronisers; clk_prev gives the previous synchronised clock level.
  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  logic fall;
  assign fall = clk_prev & ~clk_s2;

  rx_state_t        state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [WD_W-1:0]  wd_cnt;
  logic             ext_f, rel_f;
  logic [2:0]       skip_cnt;
  logic             push_q;
  logic [9:0]       push_data;

  logic stop_fall, frame_ok, wd_expire, frame_err;
  assign stop_fall = fall && (state == S_STOP);
  // Valid frame: stop bit high and odd parity over data + parity bit.
  assign frame_ok  = dat_s2 && (^{par_bit, shreg});
  // Watchdog is a down-counter reloaded on every falling edge.
  assign wd_expire = (state != S_IDLE) && !fall && (wd_cnt == '0);
  assign frame_err = (stop_fall && !frame_ok) || wd_expire;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      wd_cnt    <= WD_W'(TIMEOUT - 1);
      ext_f     <= 1'b0;
      rel_f     <= 1'b0;
      skip_cnt  <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      err_cnt   <= '0;
    end else begin
      push_q <= 1'b0;

      if (fall) begin
        wd_cnt <= WD_W'(TIMEOUT - 1);
      end else if (state != S_IDLE && wd_cnt != '0) begin
        wd_cnt <= wd_cnt - 1'b1;
      end

      if (wd_expire) begin
        state <= S_IDLE;
      end else if (fall) begin
        case (state)
          S_IDLE: begin
            if (!dat_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= dat_s2;
            state   <= S_STOP;
          end
          S_STOP: begin
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end

      if (frame_err) begin
        ext_f    <= 1'b0;
        rel_f    <= 1'b0;
        skip_cnt <= '0;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (stop_fall) begin
        // The Pause sequence is E1 followed by 7 bytes; it collapses to a
        // single extended make of 0x77 once the last byte arrives.
        if (skip_cnt != '0) begin
          skip_cnt <= skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            push_q    <= 1'b1;
            push_data <= {2'b10, 8'h77};
          end
        end else if (shreg == CODE_E1) begin
          skip_cnt <= 3'd7;
        end else if (shreg == CODE_E0) begin
          ext_f <= 1'b1;
        end else if (shreg == CODE_F0) begin
          rel_f <= 1'b1;
        end else begin
          push_q    <= 1'b1;
          push_data <= {ext_f, rel_f, shreg};
          ext_f     <= 1'b0;
          rel_f     <= 1'b0;
        end
      end
    end
  end

  // Event FIFO; the extra pointer bit separates full from empty.
  logic [FIFO_BITS:0] wr_ptr, rd_ptr;
  logic [9:0]         mem [DEPTH];
  logic [9:0]         last_data;
  logic               empty, full, pop, push_ok, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_BITS] != rd_ptr[FIFO_BITS]) &&
                   (wr_ptr[FIFO_BITS-1:0] == rd_ptr[FIFO_BITS-1:0]);
  assign ev_valid = !empty;
  assign pop     = ev_valid && ev_ready;
  assign push_ok = push_q && (!full || pop);
  assign drop    = push_q && full && !pop;
  assign ev_data = ev_valid ? mem[rd_ptr[FIFO_BITS-1:0]] : last_data;

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr[FIFO_BITS-1:0]] <= push_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf       <= 1'b0;
      last_data <= '0;
    end else begin
      last_data <= ev_data;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed testbench for ps2_kbd_rx: drives PS/2 frames bit by bit and checks
// the decoded events, error counter, overflow flag and reset behaviour.
module tb_ps2_kbd_rx;

  localparam int TIMEOUT = 20000;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [9:0] ev_data;
  logic       ovf;
  logic       ovf_clr;
  logic [7:0] err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] evq[$];

  ps2_kbd_rx #(.TIMEOUT(TIMEOUT), .FIFO_BITS(2)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .err_cnt  (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Record every accepted event.
  always @(posedge clk_sys) begin
    if (ev_valid && ev_ready) evq.push_back(ev_data);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    wait_cyc(1);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop_bit);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_reset;
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ev_ready = 1'b1;
    ovf_clr  = 1'b0;
    wait_cyc(5);
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ev_valid: got %b expected 0", ev_valid); end
    n_tests++; if (ev_data !== 10'h000) begin n_fail++; $display("FAIL reset_ev_data: got %h expected 000", ev_data); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
    reset_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_single;
    logic [7:0] b;
    int lat;
    b = 8'h1C;
    evq.delete();
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(1'b0);
    // Stop bit driven by hand so latency can be measured from the raw edge.
    wait_cyc(1);
    ps2_data = 1'b1;
    wait_cyc(10);
    ps2_clk = 1'b0;
    lat = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk_sys); #1;
      if (ev_valid && lat == 0) lat = c;
    end
    wait_cyc(16);
    ps2_clk = 1'b1;
    wait_cyc(20);
    n_tests++; if (lat == 0) begin n_fail++; $display("FAIL single_latency: ev_valid not seen, required within 4 cycles"); end
    n_tests++; if (evq.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", evq.size()); end
    n_tests++; if (evq.size() > 0 && evq[0] !== 10'h01C) begin n_fail++; $display("FAIL single_data: got %h expected 01c", evq[0]); end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL single_err_cnt: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_prefix;
    evq.delete();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    n_tests++; if (evq.size() !== 2) begin n_fail++; $display("FAIL prefix_count: got %0d expected 2", evq.size()); end
    n_tests++; if (evq.size() > 0 && evq[0] !== 10'h375) begin n_fail++; $display("FAIL prefix_ext_rel: got %h expected 375", evq[0]); end
    n_tests++; if (evq.size() > 1 && evq[1] !== 10'h075) begin n_fail++; $display("FAIL prefix_cleared: got %h expected 075", evq[1]); end
  endtask

  task automatic test_pause;
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    evq.delete();
    for (int i = 0; i < 8; i++) send_frame(seq[i], 1'b0, 1'b1);
    n_tests++; if (evq.size() !== 1) begin n_fail++; $display("FAIL pause_count: got %0d expected 1", evq.size()); end
    n_tests++; if (evq.size() > 0 && evq[0] !== 10'h277) begin n_fail++; $display("FAIL pause_data: got %h expected 277", evq[0]); end
  endtask

  task automatic test_errors;
    logic [7:0] b;
    b = 8'h1C;
    evq.delete();
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b0);
    n_tests++; if (evq.size() !== 0) begin n_fail++; $display("FAIL err_no_events: got %0d expected 0", evq.size()); end
    n_tests++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL err_cnt_frames: got %0d expected 2", err_cnt); end
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[i]);
    wait_cyc(TIMEOUT + 10);
    n_tests++; if (err_cnt !== 8'd3) begin n_fail++; $display("FAIL err_cnt_timeout: got %0d expected 3", err_cnt); end
    send_frame(8'h29, 1'b0, 1'b1);
    n_tests++; if (evq.size() !== 1) begin n_fail++; $display("FAIL err_recover_count: got %0d expected 1", evq.size()); end
    n_tests++; if (evq.size() > 0 && evq[0] !== 10'h029) begin n_fail++; $display("FAIL err_recover_data: got %h expected 029", evq[0]); end
  endtask

  task automatic test_overflow;
    logic [7:0] codes [5];
    logic [9:0] exp  [4];
    codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    exp   = '{10'h016, 10'h01E, 10'h026, 10'h025};
    evq.delete();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(codes[i], 1'b0, 1'b1);
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf); end
    n_tests++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_head_valid: got %b expected 1", ev_valid); end
    n_tests++; if (ev_data !== 10'h016) begin n_fail++; $display("FAIL ovf_head_data: got %h expected 016", ev_data); end
    ev_ready = 1'b1;
    wait_cyc(10);
    n_tests++; if (evq.size() !== 4) begin n_fail++; $display("FAIL ovf_pop_count: got %0d expected 4", evq.size()); end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i < evq.size() && evq[i] !== exp[i]) begin n_fail++; $display("FAIL ovf_pop_order[%0d]: got %h expected %h", i, evq[i], exp[i]); end
    end
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected 0", ev_valid); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;
    wait_cyc(1);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'h5A;
    evq.delete();
    ev_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    n_tests++; if (ev_valid !== 1'b1) begin n_fail++; $display("FAIL mid_queued: got %b expected 1", ev_valid); end
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(b[i]);
    wait_cyc(1);
    reset_n = 1'b0;
    #1;
    n_tests++; if (ev_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ev_valid: got %b expected 0", ev_valid); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf: got %b expected 0", ovf); end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_err_cnt: got %0d expected 0", err_cnt); end
    wait_cyc(3);
    reset_n = 1'b1;
    ev_ready = 1'b1;
    wait_cyc(5);
    evq.delete();
    send_frame(8'h5A, 1'b0, 1'b1);
    n_tests++; if (evq.size() !== 1) begin n_fail++; $display("FAIL mid_after_count: got %0d expected 1", evq.size()); end
    n_tests++; if (evq.size() > 0 && evq[0] !== 10'h05A) begin n_fail++; $display("FAIL mid_after_data: got %h expected 05a", evq[0]); end
    n_tests++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_after_err: got %0d expected 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_pause();
    test_errors();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
